// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
//   BCD_W      : width of one packed BCD digit
//   state_t    : control FSM states (IDLE, RUN, DONE)
//   nines_comp : nine's complement of one digit, taken modulo 16 so that
//                out-of-range digits still yield a defined 4-bit value
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] digit);
        return 4'd9 - digit;
    endfunction

endpackage

// File: rtl/bcd_digit_slice.sv
// One-digit combinational BCD add/subtract slice.
// Ports:
//   a_d  [3:0] in  : digit of operand A
//   b_d  [3:0] in  : digit of operand B (complemented internally when sub=1)
//   cin        in  : decimal carry into this digit
//   sub        in  : 1 = use nine's complement of b_d
//   s_d  [3:0] out : result digit
//   cout       out : decimal carry out of this digit
//   bad        out : a_d or b_d is not a valid BCD digit (>9)
module bcd_digit_slice
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s_d,
    output logic       cout,
    output logic       bad
);

    logic [3:0] b_eff;
    logic [4:0] raw;
    logic [4:0] adj;

    assign b_eff = sub ? nines_comp(b_d) : b_d;
    assign raw   = {1'b0, a_d} + {1'b0, b_eff} + {4'b0000, cin};
    // Adding 6 skips the six unused codes 10..15 and wraps into the next decade.
    assign adj   = raw + 5'd6;

    assign cout  = (raw > 5'd9);
    assign s_d   = cout ? adj[3:0] : raw[3:0];
    assign bad   = (a_d > 4'd9) || (b_d > 4'd9);

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LS digit first.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake; in_ready is high only when idle
//   a, b   [4*NDIGITS]  : packed BCD operands, digit 0 in bits [3:0]
//   cin                 : carry-in (add) or borrow-in (subtract)
//   sub                 : 0 = A+B+cin, 1 = A-B-cin
//   out_valid/out_ready : result handshake; outputs frozen while out_valid=1
//   sum    [4*NDIGITS]  : packed BCD result
//   c_out               : add: decimal carry; sub: 1 = no borrow
//   err                 : some input digit of this operation was >9
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BCD_W*NDIGITS-1:0] a,
    input  logic [BCD_W*NDIGITS-1:0] b,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BCD_W*NDIGITS-1:0] sum,
    output logic                     c_out,
    output logic                     err
);

    localparam int W     = BCD_W * NDIGITS;
    localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIGITS - 1);

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             sub_reg;
    logic             carry_reg;
    logic [W-1:0]     result_reg;
    logic             err_acc_reg;
    logic [CNT_W-1:0] idx_reg;
    logic [W-1:0]     sum_reg;
    logic             c_out_reg;
    logic             err_reg;

    logic [3:0]       slice_s;
    logic             slice_cout;
    logic             slice_bad;
    logic [W-1:0]     result_next;

    // Operand registers shift right each RUN cycle, so the slice always sees
    // the current digit in the low nibble.
    bcd_digit_slice u_slice (
        .a_d  (a_reg[3:0]),
        .b_d  (b_reg[3:0]),
        .cin  (carry_reg),
        .sub  (sub_reg),
        .s_d  (slice_s),
        .cout (slice_cout),
        .bad  (slice_bad)
    );

    // New digit enters at the MS end; after NDIGITS shifts digit 0 is in [3:0].
    assign result_next = (result_reg >> BCD_W) | (W'(slice_s) << (W - BCD_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sub_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            result_reg  <= '0;
            err_acc_reg <= 1'b0;
            idx_reg     <= '0;
            sum_reg     <= '0;
            c_out_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg       <= a;
                        b_reg       <= b;
                        sub_reg     <= sub;
                        // Subtraction is A + nines(B) + 1 - borrow, so the
                        // incoming borrow becomes an inverted carry.
                        carry_reg   <= sub ? ~cin : cin;
                        result_reg  <= '0;
                        err_acc_reg <= 1'b0;
                        idx_reg     <= '0;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    a_reg       <= a_reg >> BCD_W;
                    b_reg       <= b_reg >> BCD_W;
                    carry_reg   <= slice_cout;
                    result_reg  <= result_next;
                    err_acc_reg <= err_acc_reg | slice_bad;
                    idx_reg     <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        // Publish the finished result together with the
                        // state change so outputs are settled with out_valid.
                        sum_reg   <= result_next;
                        c_out_reg <= slice_cout;
                        err_reg   <= err_acc_reg | slice_bad;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (NDIGITS=4): directed vector table,
// backpressure and mid-operation reset sequences, and randomized operations
// checked against an integer-arithmetic decimal model.
module tb_bcd_serial_addsub;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_serial_addsub #(.NDIGITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- decimal reference model ----------------
    function automatic longint bcd2int(input logic [W-1:0] x);
        longint v = 0;
        for (int i = N - 1; i >= 0; i--) v = v * 10 + longint'(x[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < N; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                             input logic rcin, input logic rsub,
                             output logic [W-1:0] rs, output logic rc);
        longint m = 1;
        longint t;
        for (int i = 0; i < N; i++) m = m * 10;
        if (!rsub) begin
            t  = bcd2int(ra) + bcd2int(rb) + longint'(rcin);
            rc = (t >= m);
            rs = int2bcd(t % m);
        end else begin
            t = bcd2int(ra) - bcd2int(rb) - longint'(rcin);
            if (t >= 0) begin
                rc = 1'b1;
                rs = int2bcd(t);
            end else begin
                rc = 1'b0;
                rs = int2bcd(t + m);
            end
        end
    endtask

    // ---------------- one operation through the handshake ----------------
    // Drives one operand set, checks latency, optionally holds out_ready low
    // for 'hold' cycles (checking stability and ignored in_valid), then
    // releases the result and checks the return to IDLE.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic ocin, input logic osub, input int hold,
                         output logic [W-1:0] os, output logic oc, output logic oe);
        int cnt;
        int waited;
        @(negedge clk);
        a = oa; b = ob; cin = ocin; sub = osub;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);          // accepting edge
        @(negedge clk);
        in_valid = 1'b0;
        a = '0; b = '0;          // operands must have been captured
        cnt = 0;
        while (cnt < 3 * N) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (out_valid) break;
        end
        // out_valid appears on the NDIGITS-th edge after the accepting edge,
        // i.e. NDIGITS+1 edges counting the accepting edge itself.
        check("latency_edges_incl_accept", 32'(cnt + 1), 32'(N + 1));
        os = sum; oc = c_out; oe = err;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a = ~oa; b = ~ob;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_sum",       32'(sum),       32'(os));
            check("hold_c_out_err", {30'd0, c_out, err}, {30'd0, oc, oe});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready",  32'(in_ready),  32'd1);
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic         vsub;
        int           vhold;
        logic [W-1:0] es;
        logic         ec;
        logic         ee;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] gs;
        logic         gc;
        logic         ge;
        logic [W-1:0] ms;
        logic         mc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rcin;
        logic         rsub;
        logic         bad;
        int           hold;

        vecs[0] = '{16'h0999, 16'h0001, 1'b0, 1'b0, 0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h9999, 1'b1, 1'b0, 0, 16'h9999, 1'b1, 1'b0};
        vecs[2] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 3, 16'h0999, 1'b1, 1'b0};
        vecs[3] = '{16'h0001, 16'h0002, 1'b0, 1'b1, 0, 16'h9999, 1'b0, 1'b0};
        vecs[4] = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b1};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0};
        vecs[6] = '{16'h5000, 16'h4999, 1'b1, 1'b1, 1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 0, 16'h9999, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum",       32'(sum),       32'd0);
        check("reset_c_out_err", {30'd0, c_out, err}, 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, vecs[i].vhold, gs, gc, ge);
            $display("vec %0d: a=%h b=%h cin=%0d sub=%0d -> sum=%h c_out=%0d err=%0d",
                     i, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, gs, gc, ge);
            check($sformatf("vec%0d_sum", i),   32'(gs), 32'(vecs[i].es));
            check($sformatf("vec%0d_c_out", i), 32'(gc), 32'(vecs[i].ec));
            check($sformatf("vec%0d_err", i),   32'(ge), 32'(vecs[i].ee));
        end

        // Reset while digit 2 is being processed.
        @(negedge clk);
        a = 16'h8888; b = 16'h7777; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);          // accepting edge
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);          // digit 0 done
        @(negedge clk);          // digit 1 done, digit 2 in flight
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready",  32'(in_ready),  32'd1);
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_sum",       32'(sum),       32'd0);
        check("midrun_rst_c_out_err", {30'd0, c_out, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) begin
            @(negedge clk);
            check("midrun_rst_no_result", 32'(out_valid), 32'd0);
        end
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, gs, gc, ge);
        $display("post-reset: a=1234 b=4321 -> sum=%h c_out=%0d err=%0d", gs, gc, ge);
        check("post_rst_sum",   32'(gs), 32'h5555);
        check("post_rst_c_out", 32'(gc), 32'd0);
        check("post_rst_err",   32'(ge), 32'd0);

        // Random valid-digit operations against the decimal model.
        for (int t = 0; t < 40; t++) begin
            for (int d = 0; d < N; d++) begin
                ra[d*4 +: 4] = 4'($urandom_range(0, 9));
                rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            rcin = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 2));
            ref_model(ra, rb, rcin, rsub, ms, mc);
            do_op(ra, rb, rcin, rsub, hold, gs, gc, ge);
            $display("rand %0d: a=%h b=%h cin=%0d sub=%0d -> sum=%h c_out=%0d err=%0d (model %h %0d)",
                     t, ra, rb, rcin, rsub, gs, gc, ge, ms, mc);
            check("rand_sum",   32'(gs), 32'(ms));
            check("rand_c_out", 32'(gc), 32'(mc));
            check("rand_err",   32'(ge), 32'd0);
        end

        // Random operands allowing invalid digits: only the error flag is modelled.
        for (int t = 0; t < 12; t++) begin
            bad = 1'b0;
            for (int d = 0; d < N; d++) begin
                ra[d*4 +: 4] = 4'($urandom_range(0, 15));
                rb[d*4 +: 4] = 4'($urandom_range(0, 15));
                if (ra[d*4 +: 4] > 4'd9 || rb[d*4 +: 4] > 4'd9) bad = 1'b1;
            end
            rsub = 1'($urandom_range(0, 1));
            do_op(ra, rb, 1'b0, rsub, 0, gs, gc, ge);
            $display("rand_inv %0d: a=%h b=%h sub=%0d -> err=%0d", t, ra, rb, rsub, ge);
            check("rand_inv_err", 32'(ge), 32'(bad));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
